updown_counter_ext: RTL and testbench

//  Parametrised up/down counter: configurable width and modulus, variable step,

---
 rtl/updown_counter_ext_pkg.sv | 19 +
 rtl/updown_counter_ext_if.sv | 30 +++
 rtl/updown_counter_ext_next.sv | 57 +++++
 rtl/updown_counter_ext.sv | 94 +++++++++
 tb/tb_updown_counter_ext.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/updown_counter_ext_pkg.sv
// Shared types for the up/down counter: direction, limit mode and pulse flags.
package updown_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    typedef struct packed {
        logic ovf;
        logic unf;
    } counter_flags_t;

endpackage

// File: rtl/updown_counter_ext_if.sv
// Control and status bundle for the up/down counter.
// The master drives the controls; the slave (the counter) drives the status.
interface updown_counter_ext_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic              en;
    logic              UpOrDown;
    logic [STEP_W-1:0] step;
    logic              sat_mode;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic              clear;
    logic [WIDTH-1:0]  count;
    logic              ovf;
    logic              unf;
    logic              ovf_sticky;
    logic              unf_sticky;
    logic              tc;

    modport master (
        output en, UpOrDown, step, sat_mode, load, load_val, clear,
        input  count, ovf, unf, ovf_sticky, unf_sticky, tc
    );

    modport slave (
        input  en, UpOrDown, step, sat_mode, load, load_val, clear,
        output count, ovf, unf, ovf_sticky, unf_sticky, tc
    );
endinterface

// File: rtl/updown_counter_ext_next.sv
// Combinational step evaluator: computes the counter value after one
// enabled step, in either direction, wrapping or saturating at the bounds.
module updown_next
    import updown_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 2**WIDTH - 1,
    parameter int STEP_W  = 4
) (
    input  logic [WIDTH-1:0]  count_i,
    input  logic [STEP_W-1:0] step_i,
    input  dir_e              dir_i,
    input  mode_e             mode_i,
    output logic [WIDTH-1:0]  next_count_o,
    output counter_flags_t    flags_o
);

    // One spare bit above the wider operand so neither the sum nor the
    // wrapped down-count can overflow the working width.
    localparam int EXT_W = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;
    localparam logic [EXT_W-1:0] MAX_EXT = EXT_W'(MAX_VAL);
    localparam logic [EXT_W-1:0] MOD_EXT = EXT_W'(MAX_VAL + 1);

    logic [EXT_W-1:0] countExt;
    logic [EXT_W-1:0] stepExt;
    logic [EXT_W-1:0] sumExt;
    logic [EXT_W-1:0] result;

    assign countExt = EXT_W'(count_i);
    assign stepExt  = EXT_W'(step_i);
    assign sumExt   = countExt + stepExt;

    // Crossing a bound raises the matching flag even when saturation pins
    // the count, so a saturated counter sitting at a bound keeps pulsing.
    always_comb begin
        result  = countExt;
        flags_o = '0;
        if (dir_i == DIR_UP) begin
            if (sumExt > MAX_EXT) begin
                flags_o.ovf = 1'b1;
                result      = (mode_i == MODE_SAT) ? MAX_EXT : (sumExt - MOD_EXT);
            end else begin
                result = sumExt;
            end
        end else begin
            if (stepExt > countExt) begin
                flags_o.unf = 1'b1;
                result      = (mode_i == MODE_SAT) ? '0 : (countExt + MOD_EXT - stepExt);
            end else begin
                result = countExt - stepExt;
            end
        end
    end

    assign next_count_o = result[WIDTH-1:0];

endmodule

// File: rtl/updown_counter_ext.sv
// Parametrised up/down counter with load, clear, wrap/saturate and
// registered overflow/underflow pulses plus sticky flags.
module updown_counter_ext
    import updown_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_VAL   = 2**WIDTH - 1,
    parameter int STEP_W    = 4,
    parameter int RESET_VAL = 0
) (
    input logic                clk,
    input logic                reset,
    updown_counter_ext_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_C = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    counter_flags_t   flags_q, flags_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic             unf_sticky_q, unf_sticky_d;

    logic [WIDTH-1:0] stepCount;
    counter_flags_t   stepFlags;
    logic [WIDTH-1:0] loadClamped;
    logic             stepIllegal;

    updown_next #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .STEP_W  (STEP_W)
    ) u_next (
        .count_i      (count_q),
        .step_i       (bus.step),
        .dir_i        (dir_e'(bus.UpOrDown)),
        .mode_i       (mode_e'(bus.sat_mode)),
        .next_count_o (stepCount),
        .flags_o      (stepFlags)
    );

    assign loadClamped = (bus.load_val > MAX_C) ? MAX_C : bus.load_val;

    // Priority mux: clear beats load beats counting; pulses only come from
    // an enabled step and feed the sticky flags in the same cycle.
    always_comb begin
        count_d      = count_q;
        flags_d      = '0;
        ovf_sticky_d = ovf_sticky_q;
        unf_sticky_d = unf_sticky_q;
        if (bus.clear) begin
            count_d      = RST_C;
            ovf_sticky_d = 1'b0;
            unf_sticky_d = 1'b0;
        end else if (bus.load) begin
            count_d = loadClamped;
        end else if (bus.en) begin
            count_d      = stepCount;
            flags_d      = stepFlags;
            ovf_sticky_d = ovf_sticky_q | stepFlags.ovf;
            unf_sticky_d = unf_sticky_q | stepFlags.unf;
        end
    end

    // State registers with synchronous active-low reset overriding all inputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q      <= RST_C;
            flags_q      <= '0;
            ovf_sticky_q <= 1'b0;
            unf_sticky_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            flags_q      <= flags_d;
            ovf_sticky_q <= ovf_sticky_d;
            unf_sticky_q <= unf_sticky_d;
        end
    end

    assign bus.count      = count_q;
    assign bus.ovf        = flags_q.ovf;
    assign bus.unf        = flags_q.unf;
    assign bus.ovf_sticky = ovf_sticky_q;
    assign bus.unf_sticky = unf_sticky_q;
    assign bus.tc         = (bus.UpOrDown && (count_q == MAX_C)) ||
                            (!bus.UpOrDown && (count_q == '0));

    // A step wider than the count range has no defined result.
    assign stepIllegal = bus.en && !bus.load && !bus.clear && (int'(bus.step) > MAX_VAL);

    a_step_legal: assert property (@(posedge clk) !(reset && stepIllegal));
    a_flags_excl: assert property (@(posedge clk) !(flags_q.ovf && flags_q.unf));

endmodule

// File: tb/tb_updown_counter_ext.sv
// Scoreboard bench for updown_counter_ext with WIDTH=4, MAX_VAL=9.
module tb_updown_counter_ext;

    localparam int WIDTH   = 4;
    localparam int MAX_VAL = 9;
    localparam int STEP_W  = 4;

    typedef struct {
        int count;
        int ovf;
        int unf;
        int ovfS;
        int unfS;
        int up;
    } exp_t;

    logic clk;
    logic reset;

    updown_counter_ext_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

    updown_counter_ext #(
        .WIDTH     (WIDTH),
        .MAX_VAL   (MAX_VAL),
        .STEP_W    (STEP_W),
        .RESET_VAL (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    exp_t expQ[$];
    int   mCount;
    int   mOvfS;
    int   mUnfS;
    int   checkCount;
    int   errCount;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, predict the result, then compare after the edge.
    task automatic applyStimulus(input int rst, input int en, input int up, input int step,
                                 input int sat, input int ld, input int lv, input int clr);
        exp_t e;
        exp_t got;
        int   s;
        int   pOvf;
        int   pUnf;
        @(negedge clk);
        reset        = rst[0];
        bus.en       = en[0];
        bus.UpOrDown = up[0];
        bus.step     = STEP_W'(step);
        bus.sat_mode = sat[0];
        bus.load     = ld[0];
        bus.load_val = WIDTH'(lv);
        bus.clear    = clr[0];
        pOvf = 0;
        pUnf = 0;
        if (rst == 0) begin
            mCount = 0; mOvfS = 0; mUnfS = 0;
        end else if (clr != 0) begin
            mCount = 0; mOvfS = 0; mUnfS = 0;
        end else if (ld != 0) begin
            mCount = (lv > MAX_VAL) ? MAX_VAL : lv;
        end else if (en != 0 && step != 0) begin
            if (up != 0) begin
                s = mCount + step;
                if (s > MAX_VAL) begin
                    pOvf   = 1;
                    mCount = (sat != 0) ? MAX_VAL : s - (MAX_VAL + 1);
                end else begin
                    mCount = s;
                end
            end else begin
                if (step > mCount) begin
                    pUnf   = 1;
                    mCount = (sat != 0) ? 0 : mCount + (MAX_VAL + 1) - step;
                end else begin
                    mCount = mCount - step;
                end
            end
        end
        if (pOvf != 0) mOvfS = 1;
        if (pUnf != 0) mUnfS = 1;
        e.count = mCount; e.ovf = pOvf; e.unf = pUnf;
        e.ovfS = mOvfS; e.unfS = mUnfS; e.up = up;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            checkOutput("scoreboard_empty", 0, 1);
        end else begin
            got = expQ.pop_front();
            checkOutput("count", int'(bus.count), got.count);
            checkOutput("ovf", int'(bus.ovf), got.ovf);
            checkOutput("unf", int'(bus.unf), got.unf);
            checkOutput("ovf_sticky", int'(bus.ovf_sticky), got.ovfS);
            checkOutput("unf_sticky", int'(bus.unf_sticky), got.unfS);
            checkOutput("tc", int'(bus.tc),
                        ((got.up != 0 && got.count == MAX_VAL) || (got.up == 0 && got.count == 0)) ? 1 : 0);
        end
    endtask

    initial begin
        checkCount = 0;
        errCount   = 0;
        mCount     = 0;
        mOvfS      = 0;
        mUnfS      = 0;
        reset        = 1'b0;
        bus.en       = 1'b0;
        bus.UpOrDown = 1'b1;
        bus.step     = '0;
        bus.sat_mode = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        bus.clear    = 1'b0;

        // Reset, then count up by one through the wrap at 9.
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) applyStimulus(1, 1, 1, 1, 0, 0, 0, 0);
        checkOutput("ovf_sticky_after_wrap", int'(bus.ovf_sticky), 1);

        // Down-step below zero: wrap then saturate.
        applyStimulus(1, 0, 0, 0, 0, 1, 2, 0);
        applyStimulus(1, 1, 0, 3, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 2, 0);
        applyStimulus(1, 1, 0, 3, 1, 0, 0, 0);

        // Saturating up-step keeps pulsing ovf at the bound.
        applyStimulus(1, 0, 1, 0, 1, 1, 7, 0);
        applyStimulus(1, 1, 1, 5, 1, 0, 0, 0);
        applyStimulus(1, 1, 1, 5, 1, 0, 0, 0);

        // Load clamping and clear beating load.
        applyStimulus(1, 0, 1, 0, 0, 1, 15, 0);
        applyStimulus(1, 1, 1, 3, 0, 1, 5, 1);

        // Reset in the middle of a counting run.
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1, 4, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 4, 0, 1, 6, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 4, 0, 0, 0, 0);

        // Holding via en=0 and via step=0, at the terminal count.
        applyStimulus(1, 0, 1, 0, 0, 1, 9, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, 7, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0);

        // Random mix of legal controls.
        for (int i = 0; i < 60; i++) begin
            applyStimulus(($urandom_range(0, 19) == 0) ? 0 : 1,
                          int'($urandom_range(0, 3) != 0),
                          int'($urandom_range(0, 1)),
                          int'($urandom_range(0, MAX_VAL)),
                          int'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) == 0) ? 1 : 0,
                          int'($urandom_range(0, 15)),
                          ($urandom_range(0, 14) == 0) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
